// File: rtl/wave_pkg.sv
// Shared types and constants for the audio waveform blocks (oscillators, period meter).
package wave_pkg;

  typedef logic signed [31:0] sample_t;

  localparam int FRAC_BITS = 20;
  localparam int ONE       = 1 << FRAC_BITS;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/hyst_crossing_detector.sv
// Rising-crossing detector with hysteresis: a sample below -HYST arms it, the next
// sample at or above +HYST fires trig for that cycle and disarms.
module hyst_crossing_detector
  import wave_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int HYST  = 1 << 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] sample,
  output logic                    trig
);

  localparam logic signed [WIDTH-1:0] HYST_POS = WIDTH'(HYST);
  localparam logic signed [WIDTH-1:0] HYST_NEG = -HYST_POS;

  logic armed;
  logic below;
  logic above;

  always_comb begin
    below = sample < HYST_NEG;
    above = sample >= HYST_POS;
    trig  = sample_valid && armed && above;
  end

  // clear (timeout) dominates a simultaneous arming sample
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      armed <= 1'b0;
    end else if (sample_valid) begin
      if (below) begin
        armed <= 1'b1;
      end else if (trig) begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wave_period_meter.sv
// Period meter: counts clocks between hysteretic rising crossings and reports the
// average over 2**AVG_LOG2 periods as wave_length = period - 1.
//
//   state   | meaning
//   IDLE    | waiting for the first crossing; no period reference yet
//   MEASURE | counting clocks since the last crossing, accumulating periods
module wave_period_meter
  import wave_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HYST       = 1 << 16,
  parameter int AVG_LOG2   = 2,
  parameter int MAX_PERIOD = 1 << 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] sample,
  output logic [WIDTH-1:0]        wave_length,
  output logic                    period_valid,
  output logic                    locked,
  output logic                    timeout
);

  localparam int CNT_W = $clog2(MAX_PERIOD);
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PERIOD - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);

  meter_state_t     state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [ACC_W-1:0] acc, acc_d, acc_sum;
  logic [N_W-1:0]   n, n_d;
  logic [WIDTH-1:0] wave_length_d;
  logic             period_valid_d, locked_d, timeout_d;
  logic             trig, det_clear;

  hyst_crossing_detector #(
    .WIDTH (WIDTH),
    .HYST  (HYST)
  ) u_detector (
    .clk          (clk),
    .reset        (reset),
    .clear        (det_clear),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig         (trig)
  );

  always_comb begin
    // acc plus the period ending this cycle (count+1 clocks)
    acc_sum        = acc + ACC_W'(count) + ACC_W'(1);
    state_d        = state;
    count_d        = count;
    acc_d          = acc;
    n_d            = n;
    wave_length_d  = wave_length;
    period_valid_d = 1'b0;
    locked_d       = locked;
    timeout_d      = 1'b0;
    det_clear      = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_d = MEASURE;
          count_d = '0;
          acc_d   = '0;
          n_d     = '0;
        end
      end
      MEASURE: begin
        if (trig) begin
          count_d = '0;
          if (n == N_LAST) begin
            wave_length_d  = WIDTH'((acc_sum >> AVG_LOG2) - ACC_W'(1));
            period_valid_d = 1'b1;
            locked_d       = 1'b1;
            acc_d          = '0;
            n_d            = '0;
          end else begin
            acc_d = acc_sum;
            n_d   = n + N_W'(1);
          end
        end else if (count == CNT_LAST) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          det_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      n            <= '0;
      wave_length  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      acc          <= acc_d;
      n            <= n_d;
      wave_length  <= wave_length_d;
      period_valid <= period_valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wave_period_meter.sv
// Bench for wave_period_meter: vector table, directed corner sequences, and random
// stimulus checked every cycle against a timestamp-based reference model.
module tb_wave_period_meter;
  import wave_pkg::*;

  localparam int WIDTH      = 32;
  localparam int HYST       = 1 << 16;
  localparam int AVG_LOG2   = 2;
  localparam int NAVG       = 1 << AVG_LOG2;
  localparam int MAX_PERIOD = 1000;
  localparam int AMP        = 524288;

  localparam int K_SAW    = 0;
  localparam int K_SQUARE = 1;
  localparam int K_NOISY  = 2;
  localparam int K_PULSE  = 3;

  typedef struct {
    int kind;
    int per;
    int exp_wl;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_valid = 1'b0;
  logic signed [WIDTH-1:0] sample = '0;
  logic [WIDTH-1:0] wave_length;
  logic period_valid, locked, timeout;

  int checks = 0;
  int passes = 0;
  int pv_seen = 0;
  int to_seen = 0;

  always #5 clk = ~clk;

  wave_period_meter #(
    .WIDTH      (WIDTH),
    .HYST       (HYST),
    .AVG_LOG2   (AVG_LOG2),
    .MAX_PERIOD (MAX_PERIOD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .wave_length  (wave_length),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  // Reference model: crossings are timestamped; periods are timestamp differences.
  logic m_armed = 1'b0;
  logic m_meas = 1'b0;
  logic m_trig;
  int m_cyc = 0;
  int m_last = 0;
  int m_q[$];
  longint m_sum;
  logic [WIDTH-1:0] e_wl = '0;
  logic e_pv = 1'b0, e_lock = 1'b0, e_to = 1'b0;

  always @(negedge clk) begin
    checks++;
    if (wave_length === e_wl && period_valid === e_pv && locked === e_lock && timeout === e_to)
      passes++;
    else
      $display("FAIL cycle_model cyc=%0d got wl=%0d pv=%b lock=%b to=%b expected wl=%0d pv=%b lock=%b to=%b",
               m_cyc, wave_length, period_valid, locked, timeout, e_wl, e_pv, e_lock, e_to);
    if (period_valid === 1'b1) pv_seen++;
    if (timeout === 1'b1) to_seen++;

    m_cyc++;
    e_pv = 1'b0;
    e_to = 1'b0;
    if (reset) begin
      m_armed = 1'b0;
      m_meas  = 1'b0;
      m_q.delete();
      e_wl    = '0;
      e_lock  = 1'b0;
    end else begin
      m_trig = sample_valid && m_armed && (sample >= HYST);
      if (sample_valid) begin
        if (sample < -HYST) m_armed = 1'b1;
        else if (m_trig) m_armed = 1'b0;
      end
      if (m_trig) begin
        if (m_meas) begin
          m_q.push_back(m_cyc - m_last);
          if (m_q.size() == NAVG) begin
            m_sum = 0;
            foreach (m_q[i]) m_sum += m_q[i];
            e_wl   = WIDTH'(m_sum / NAVG - 1);
            e_pv   = 1'b1;
            e_lock = 1'b1;
            m_q.delete();
          end
        end
        m_meas = 1'b1;
        m_last = m_cyc;
      end else if (m_meas && (m_cyc - m_last == MAX_PERIOD)) begin
        e_to    = 1'b1;
        e_lock  = 1'b0;
        m_armed = 1'b0;
        m_meas  = 1'b0;
        m_q.delete();
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  task automatic drive(input logic signed [WIDTH-1:0] v, input logic vld);
    @(posedge clk);
    #1;
    sample = v;
    sample_valid = vld;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sample = '0;
    sample_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic signed [WIDTH-1:0] wave_val(input int kind, input int k, input int s);
    case (kind)
      K_SAW:   return -ONE + (2 * ONE / s) * k;
      K_NOISY: begin
        if (k < 3 || (k >= s / 2 && k < s / 2 + 3)) return (k % 2 == 1) ? HYST / 2 : -HYST / 2;
        return (k < s / 2) ? AMP : -AMP;
      end
      K_PULSE: return (k == 0) ? ONE : -ONE;
      default: return (k < s / 2) ? AMP : -AMP;
    endcase
  endfunction

  task automatic run_period(input int kind, input int s);
    for (int k = 0; k < s; k++) drive(wave_val(kind, k, s), 1'b1);
  endtask

  vec_t vecs[6];
  int pv0, to0;
  logic signed [WIDTH-1:0] rv;

  initial begin
    vecs[0] = '{K_SAW,    100,  99};
    vecs[1] = '{K_SQUARE,  37,  36};
    vecs[2] = '{K_SQUARE,   2,   1};
    vecs[3] = '{K_SQUARE,   3,   2};
    vecs[4] = '{K_NOISY,   64,  63};
    vecs[5] = '{K_SQUARE, 1000, 999};

    apply_reset(3);
    check("reset_wave_length", wave_length, 0);
    check("reset_period_valid", period_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_timeout", timeout, 0);

    foreach (vecs[v]) begin
      apply_reset(2);
      for (int p = 0; p < 6; p++) run_period(vecs[v].kind, vecs[v].per);
      check($sformatf("vec%0d_wave_length", v), wave_length, vecs[v].exp_wl);
      check($sformatf("vec%0d_locked", v), locked, 1);
    end

    // uneven spacings 100,101,100,103 average to 101 (truncating)
    apply_reset(2);
    repeat (5) drive(-ONE, 1'b1);
    run_period(K_PULSE, 100);
    run_period(K_PULSE, 101);
    run_period(K_PULSE, 100);
    run_period(K_PULSE, 103);
    run_period(K_PULSE, 10);
    check("uneven_wave_length", wave_length, 100);

    // loss of signal after lock
    to0 = to_seen;
    repeat (1010) drive('0, 1'b1);
    check("timeout_count", to_seen - to0, 1);
    check("timeout_locked", locked, 0);
    check("timeout_wl_hold", wave_length, 100);

    // reset while two periods are accumulated
    apply_reset(2);
    drive(-ONE, 1'b1);
    repeat (7) run_period(K_PULSE, 20);
    check("pre_reset_locked", locked, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset_wave_length", wave_length, 0);
    check("midreset_locked", locked, 0);
    check("midreset_pv", period_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(-ONE, 1'b1);
    pv0 = pv_seen;
    repeat (4) run_period(K_PULSE, 10);
    check("after_reset_4trig_pv", pv_seen - pv0, 0);
    run_period(K_PULSE, 10);
    check("after_reset_5trig_pv", pv_seen - pv0, 1);
    check("after_reset_wl", wave_length, 9);

    // random segments, checked cycle by cycle by the model
    for (int seg = 0; seg < 150; seg++) begin
      int m, s, np, kind;
      m = $urandom_range(0, 19);
      if (m == 0) begin
        apply_reset($urandom_range(1, 2));
      end else if (m == 1) begin
        repeat ($urandom_range(950, 1050)) drive(int'($urandom_range(0, HYST)) - HYST / 2, 1'b1);
      end else if (m < 4) begin
        repeat (50) begin
          rv = $urandom;
          drive(rv, 1'($urandom_range(0, 1)));
        end
      end else begin
        s = $urandom_range(2, 80);
        np = $urandom_range(1, 6);
        kind = ($urandom_range(0, 1) == 1) ? K_PULSE : K_SQUARE;
        repeat (np)
          for (int k = 0; k < s; k++)
            drive(wave_val(kind, k, s), 1'($urandom_range(0, 7) != 0));
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
